tx_frame_streamer: RTL and testbench

- Paced, multi-channel frame source that reads DATA_W-bit words from a synchronous source memory.
- Emits them as framed words on the Ethernet MAC transmit FIFO interface, using ff_tx_data, sop, eop, mod, wren and rdy.
- Generalises the fixed half-second, single-word memory feed: configurable width, frame length, pacing period and channel count, with full rdy backpressure.
- Sits between the source memory and the MAC TX FIFO port, in the clk_hifreq domain.

---
 rtl/tx_frame_streamer_pkg.sv | 19 +
 rtl/tx_frame_streamer_pace_tick_gen.sv | 28 ++
 rtl/tx_frame_streamer.sv | 145 ++++++++++++++
 tb/tb_tx_frame_streamer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_streamer_pkg.sv
// Shared types and helpers for the paced TX frame streamer: FSM states,
// frame-length clamping and the sequence-stamp word layout.
package tx_stream_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  // Stamp word, MSB first: {channel byte, tag byte, frame counter}, then zero pad
  localparam int STAMP_CH_W  = 8;
  localparam int STAMP_CNT_W = 16;
  localparam logic [7:0] STAMP_TAG = 8'h01;
  localparam int STAMP_W     = STAMP_CH_W + 8 + STAMP_CNT_W;

  function automatic int unsigned clamp_len(input int unsigned raw, input int unsigned max_words);
    if (raw == 0) return 1;
    if (raw > max_words) return max_words;
    return raw;
  endfunction

endpackage

// File: rtl/tx_frame_streamer_pace_tick_gen.sv
// Frame pacing counter: counts 0..PERIOD_CYCLES-1 while enabled and pulses
// tick on the wrap; parked at zero while disabled.
module pace_tick_gen #(
  parameter int PERIOD_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tx_frame_streamer.sv
// Paced multi-channel frame source feeding the MAC TX FIFO port from a
// synchronous source memory. Optional build macro: TX_SEQ_STAMP_EN.
module tx_frame_streamer
  import tx_stream_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MAX_WORDS     = 16,
  parameter int NUM_CH        = 2,
  parameter int PERIOD_CYCLES = 25000000,
  parameter int LEN_W         = $clog2(MAX_WORDS + 1),
  parameter int MOD_W         = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1,
  parameter int ADDR_W        = (NUM_CH * MAX_WORDS > 1) ? $clog2(NUM_CH * MAX_WORDS) : 1,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_hifreq,
  input  logic              rst,
  input  logic              enable,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [MOD_W-1:0]  frame_mod,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ff_tx_data,
  output logic              ff_tx_sop,
  output logic              ff_tx_eop,
  output logic [MOD_W-1:0]  ff_tx_mod,
  output logic              ff_tx_err,
  output logic              ff_tx_wren,
  input  logic              ff_tx_rdy,
  output logic [CH_W-1:0]   ch_id,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [15:0]       overrun_count
);

  state_t            state, state_nxt;
  logic              tick, pending, start, accept, last;
  logic [LEN_W-1:0]  len, idx;
  logic [MOD_W-1:0]  mod_l;
  logic [CH_W-1:0]   ch;
  logic [DATA_W-1:0] load_data;

  pace_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_pace (
    .clk    (clk_hifreq),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign start     = (state == IDLE) && pending && enable;
  assign accept    = ff_tx_wren && ff_tx_rdy;
  assign last      = (idx == len - LEN_W'(1));
  assign ff_tx_err = 1'b0;
  assign ch_id     = ch;

`ifdef TX_SEQ_STAMP_EN
  // The sop word carries a sequence stamp instead of memory data
  logic [STAMP_W-1:0]        stamp;
  logic [DATA_W+STAMP_W-1:0] stamp_ext;
  assign stamp     = {STAMP_CH_W'(ch), STAMP_TAG, STAMP_CNT_W'(frame_count)};
  assign stamp_ext = {stamp, {DATA_W{1'b0}}};
  assign load_data = (idx == '0) ? stamp_ext[DATA_W+STAMP_W-1 -: DATA_W] : mem_data;
`else
  assign load_data = mem_data;
`endif

  always_ff @(posedge clk_hifreq or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = LOAD;
      LOAD:  state_nxt = SEND;
      SEND:  if (accept) state_nxt = ff_tx_eop ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = (state == FETCH);
    mem_addr = ADDR_W'(int'(ch) * MAX_WORDS + int'(idx));
    busy     = (state != IDLE);
  end

  // A tick landing while a frame is already pending is counted as dropped
  always_ff @(posedge clk_hifreq or posedge rst) begin
    if (rst) begin
      pending       <= 1'b0;
      overrun_count <= '0;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
      if (pending && !start && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end else if (start) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_hifreq or posedge rst) begin
    if (rst) begin
      len         <= '0;
      mod_l       <= '0;
      idx         <= '0;
      ch          <= '0;
      ff_tx_data  <= '0;
      ff_tx_sop   <= 1'b0;
      ff_tx_eop   <= 1'b0;
      ff_tx_mod   <= '0;
      ff_tx_wren  <= 1'b0;
      frame_count <= '0;
    end else begin
      if (start) begin
        len   <= LEN_W'(clamp_len(32'(frame_len), MAX_WORDS));
        mod_l <= frame_mod;
        idx   <= '0;
      end
      if (state == LOAD) begin
        ff_tx_data <= load_data;
        ff_tx_sop  <= (idx == '0);
        ff_tx_eop  <= last;
        ff_tx_mod  <= last ? mod_l : '0;
        ff_tx_wren <= 1'b1;
      end
      if (state == SEND && accept) begin
        ff_tx_wren <= 1'b0;
        ff_tx_sop  <= 1'b0;
        ff_tx_eop  <= 1'b0;
        ff_tx_mod  <= '0;
        if (ff_tx_eop) begin
          frame_count <= frame_count + 16'd1;
          ch          <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
        end else begin
          idx <= idx + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_streamer.sv
// Directed scoreboard bench for tx_frame_streamer: memory model, expected-word
// and expected-address queues, stall/stability monitor.
module tb_tx_frame_streamer;

  localparam int DATA_W = 32, MAX_WORDS = 16, NUM_CH = 2, PERIOD = 100;

  logic        clk_hifreq = 1'b0;
  logic        rst = 1'b1, enable = 1'b0, ff_tx_rdy = 1'b1;
  logic [4:0]  frame_len = 5'd4;
  logic [1:0]  frame_mod = 2'd2;
  logic [4:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data = '0;
  logic [31:0] ff_tx_data;
  logic        ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_wren, busy;
  logic [1:0]  ff_tx_mod;
  logic [0:0]  ch_id;
  logic [15:0] frame_count, overrun_count;

  tx_frame_streamer #(
    .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .NUM_CH(NUM_CH), .PERIOD_CYCLES(PERIOD)
  ) dut (
    .clk_hifreq(clk_hifreq), .rst(rst), .enable(enable),
    .frame_len(frame_len), .frame_mod(frame_mod),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .ff_tx_data(ff_tx_data), .ff_tx_sop(ff_tx_sop), .ff_tx_eop(ff_tx_eop),
    .ff_tx_mod(ff_tx_mod), .ff_tx_err(ff_tx_err), .ff_tx_wren(ff_tx_wren),
    .ff_tx_rdy(ff_tx_rdy), .ch_id(ch_id), .busy(busy),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  always #5 clk_hifreq = ~clk_hifreq;

  logic [31:0] mem [0:31];
  always @(posedge clk_hifreq) if (mem_rd) mem_data <= mem[mem_addr];

  typedef struct {
    logic [31:0] data;
    logic        sop, eop;
    logic [1:0]  mod;
    logic        ch;
  } word_t;

  word_t exp_q[$];
  int    addr_q[$];
  int    tests = 0, fails = 0;
  int    exp_ch = 0, exp_fc = 0;
  bit    gap_check = 1'b0, stall_mode = 1'b0;
  int    stall_left = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int raw_len, input int m);
    int    n;
    word_t w;
    n = (raw_len == 0) ? 1 : (raw_len > MAX_WORDS) ? MAX_WORDS : raw_len;
    for (int i = 0; i < n; i++) begin
      w.data = mem[exp_ch * MAX_WORDS + i];
`ifdef TX_SEQ_STAMP_EN
      if (i == 0) w.data = {8'(exp_ch), 8'h01, 16'(exp_fc)};
`endif
      w.sop = (i == 0);
      w.eop = (i == n - 1);
      w.mod = w.eop ? 2'(m) : 2'd0;
      w.ch  = 1'(exp_ch);
      exp_q.push_back(w);
      addr_q.push_back(exp_ch * MAX_WORDS + i);
    end
    exp_ch = (exp_ch + 1) % NUM_CH;
    exp_fc++;
  endtask

  task automatic step();
    @(posedge clk_hifreq);
    #1;
    if (stall_mode) begin
      if (stall_left > 0) begin
        ff_tx_rdy = 1'b0;
        stall_left--;
      end else begin
        ff_tx_rdy  = 1'b1;
        stall_left = $urandom_range(0, 5);
      end
    end
  endtask

  task automatic wait_fc(input int target, input int budget);
    int n = 0;
    while (frame_count != 16'(target) && n < budget) begin
      step();
      n++;
    end
    check("frame_count_reached", frame_count, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"}, ff_tx_wren, 0);
    check({tag, "_sop"}, ff_tx_sop, 0);
    check({tag, "_eop"}, ff_tx_eop, 0);
    check({tag, "_mod"}, ff_tx_mod, 0);
    check({tag, "_data"}, ff_tx_data, 0);
    check({tag, "_err"}, ff_tx_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_ch_id"}, ch_id, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_overrun"}, overrun_count, 0);
  endtask

  // Monitor: addresses, accepted words, hold-stability under stall, pacing gap
  word_t held;
  bit    held_valid = 1'b0;
  int    since = 0;
  always @(negedge clk_hifreq) begin
    if (!rst) begin
      since++;
      if (mem_rd) begin
        check("addr_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (ff_tx_wren) begin
        if (held_valid) begin
          check("hold_data", ff_tx_data, held.data);
          check("hold_sop", ff_tx_sop, held.sop);
          check("hold_eop", ff_tx_eop, held.eop);
          check("hold_mod", ff_tx_mod, held.mod);
        end
        held.data = ff_tx_data; held.sop = ff_tx_sop;
        held.eop = ff_tx_eop;   held.mod = ff_tx_mod;
        held_valid = !ff_tx_rdy;
      end else begin
        held_valid = 1'b0;
      end
      if (ff_tx_wren && ff_tx_rdy) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          word_t w;
          w = exp_q.pop_front();
          check("tx_data", ff_tx_data, w.data);
          check("tx_sop", ff_tx_sop, w.sop);
          check("tx_eop", ff_tx_eop, w.eop);
          check("tx_mod", ff_tx_mod, w.mod);
          check("tx_ch_id", ch_id, w.ch);
          check("tx_err", ff_tx_err, 0);
        end
        if (gap_check && !ff_tx_sop) check("word_spacing", since, 3);
        since = 0;
      end
    end
  end

  initial begin
    int          n, seen;
    logic [31:0] sop3;
    for (int i = 0; i < 32; i++) mem[i] = ($urandom << 8) | i;

    // Reset state
    repeat (3) @(posedge clk_hifreq);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    enable = 1'b1;

    // 1: two 4-word frames, rdy high, channels 0 then 1
    gap_check = 1'b1;
    push_frame(4, 2);
    push_frame(4, 2);
    wait_fc(1, 300);
    check("ch_after_frame1", ch_id, 1);
    wait_fc(2, 300);

    // 2: random rdy stalls
    gap_check = 1'b0;
    frame_len = 5'd6; frame_mod = 2'd3;
    push_frame(6, 3);
    push_frame(6, 3);
    stall_mode = 1'b1;
    wait_fc(4, 400);
    stall_mode = 1'b0;
    ff_tx_rdy = 1'b1;

    // 3: long stall mid-frame drops a tick, then back-to-back frame
    frame_len = 5'd4; frame_mod = 2'd0;
    push_frame(4, 0);
    push_frame(4, 0);
    n = 0;
    while (!(ff_tx_wren && !ff_tx_sop) && n < 300) begin step(); n++; end
    check("stall_point_reached", ff_tx_wren && !ff_tx_sop, 1);
    ff_tx_rdy = 1'b0;
    repeat (250) @(posedge clk_hifreq);
    #1;
    check("overrun_after_stall", overrun_count, 1);
    check("wren_held_in_stall", ff_tx_wren, 1);
    ff_tx_rdy = 1'b1;
    wait_fc(5, 50);
    n = 0;
    while (!mem_rd && n < 5) begin step(); n++; end
    check("next_frame_immediate", n, 1);
    wait_fc(6, 100);
    enable = 1'b0;

    // 4: length 0 -> single word, length 20 -> clamped to 16
    gap_check = 1'b1;
    frame_len = 5'd0; frame_mod = 2'd1;
    push_frame(0, 1);
    enable = 1'b1;
    wait_fc(7, 200);
    frame_len = 5'd20; frame_mod = 2'd0;
    push_frame(20, 0);
    wait_fc(8, 200);
    check("overrun_unchanged", overrun_count, 1);

    // 5: reset during SEND of word 2, restart at first tick on channel 0
    frame_len = 5'd4;
    push_frame(4, 0);
    n = 0; seen = 0;
    while (seen < 3 && n < 300) begin
      step();
      n++;
      if (ff_tx_wren) seen++;
    end
    check("word2_reached", seen, 3);
    rst = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    addr_q.delete();
    exp_ch = 0; exp_fc = 0;
    repeat (2) @(posedge clk_hifreq);
    #1;
    rst = 1'b0;
    frame_mod = 2'd2;
    push_frame(4, 2);
    push_frame(4, 2);
    push_frame(4, 2);
    n = 0;
    while (!busy && n < 200) begin step(); n++; end
    // tick on the 100th cycle after release, FETCH on the next
    check("restart_latency", n, 101);
    check("restart_ch", ch_id, 0);

    // 6: third frame's sop word (stamped when the option is built in)
    n = 0; sop3 = '0;
    while (frame_count != 16'd3 && n < 400) begin
      step();
      n++;
      if (ff_tx_wren && ff_tx_sop && frame_count == 16'd2) sop3 = ff_tx_data;
    end
    check("frame_count_3", frame_count, 3);
`ifdef TX_SEQ_STAMP_EN
    check("third_sop_stamp", sop3, 32'h0001_0002);
`else
    check("third_sop_mem", sop3, mem[0]);
`endif
    check("scoreboard_drained", exp_q.size(), 0);
    check("addresses_drained", addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
